fpu_add_arb: RTL and testbench
==============================

Name: fpu_add_arb

Overview:
- Shares one multi-cycle floating-point adder among NUM_REQ requesters in the execute stage.
- Arbitrates requests round-robin and latches the winner's operands, holding them stable for the adder's whole normalisation run.
- Pulses the adder's new-operation strobe, waits on its busy flag, and returns the 35-bit result with the requester's id and tag.
- Bounds every operation with a timeout watchdog.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- TAG_W, 4, width of the opaque per-request tag returned with the result.
- TIMEOUT, 63, maximum WAIT cycles before the operation is aborted; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_opa  in  32*NUM_REQ  flattened operand A; requester i at [32i+31:32i].
- req_opb  in  32*NUM_REQ  flattened operand B.
- req_fsub  in  NUM_REQ  1 = subtract.
- req_tag  in  TAG_W*NUM_REQ  flattened tags.
- fpu_opa  out  32  operand A to adder.
- fpu_opb  out  32  operand B to adder.
- fpu_fsub  out  1  subtract select to adder.
- fpu_new  out  1  one-cycle start strobe to adder.
- fpu_busy  in  1  adder busy flag.
- fpu_out  in  35  adder result: sign, exp, mant, guard/round/sticky.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  35  captured result.
- res_id  out  $clog2(NUM_REQ)  index of originating requester.
- res_tag  out  TAG_W  tag of originating request.
- res_err  out  1  1 = timeout abort; res_data is 0 in that case.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Reset (rst_n=0 at a clk edge): state=IDLE.
  - Round-robin pointer = 0.
  - All outputs 0: req_ready, fpu_new, res_valid, res_err, res_data, res_id, res_tag, fpu_opa, fpu_opb, fpu_fsub.
  - Watchdog counter = 0.
  - Reset mid-operation abandons the operation; no result is produced.
- IDLE:
  - req_ready is combinational: asserted one-hot for the first requester with req_valid set, searching from the pointer upward with wrap-around.
  - On handshake (valid & ready) latch that requester's opa, opb, fsub, tag and index into operand registers.
  - Pointer <= winner+1 mod NUM_REQ; next state ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: fpu_new=1 for exactly this cycle; next state WAIT; watchdog cleared.
- WAIT:
  - fpu_new=0.
  - If fpu_busy=0: capture fpu_out into res_data, set res_err=0, go to DONE.
  - Else if watchdog==TIMEOUT-1: res_data=0, res_err=1, go to DONE.
  - Else increment the watchdog.
- DONE:
  - res_valid=1; res_data, res_id, res_tag and res_err held stable.
  - On res_ready=1, next state IDLE and res_valid drops the next cycle.
  - A new request cannot be accepted in the same cycle as the result handshake.
- fpu_opa, fpu_opb, fpu_fsub are driven from the operand registers and change only on an IDLE handshake. They are stable from ISSUE through DONE, as the adder's special-case detection is combinational on them.
- Latency: handshake at edge T, fpu_new high in cycle T+1, earliest res_valid in cycle T+3; the adder then adds 1 cycle per normalisation shift.
- Throughput: one operation in flight; req_ready=0 in all states except IDLE.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 operations.
- Inputs from non-granted requesters are ignored.
- A req_valid that drops without a handshake carries no obligation.

Test Plan:
- Reset, then single request: req0 opa=0x3F800000, opb=0x40000000, fsub=0, tag=5.
  - req_ready[0] pulses; fpu_new is high exactly 1 cycle later.
  - res_valid then asserts with res_data[34:3]=0x40400000, res_id=0, res_tag=5, res_err=0.
- Both requesters valid continuously, 4 operations: grants alternate 0,1,0,1.
  - Each result carries the matching id and tag.
  - fpu_opa is stable while fpu_busy=1.
- Special case opa=0x7F800000 (inf), opb=0x3F800000: busy drops immediately after the strobe; res_valid in cycle T+3; res_data[34:3]=0x7F800000.
- Stuck adder model holding fpu_busy=1, TIMEOUT=63: after 63 WAIT cycles res_valid=1, res_err=1, res_data=0; the next request is served normally.
- Result backpressure: res_ready held 0 for 10 cycles.
  - res_valid and res_data hold and req_ready stays 0.
  - On release, IDLE next cycle.
- rst_n asserted in WAIT: next cycle IDLE with all outputs 0 and no res_valid; the pointer restarts at requester 0.

Source files
------------

// File: rtl/fpu_add_arb.sv
// Round-robin arbiter that shares one multi-cycle FP adder among NUM_REQ requesters.
// The winner's operands stay latched from ISSUE through DONE, and every operation has a watchdog.
module fpu_add_arb #(
    parameter  int NUM_REQ = 2,
    parameter  int TAG_W   = 4,
    parameter  int TIMEOUT = 63,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [32*NUM_REQ-1:0]    req_opa,
    input  logic [32*NUM_REQ-1:0]    req_opb,
    input  logic [NUM_REQ-1:0]       req_fsub,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag,
    output logic [31:0]              fpu_opa,
    output logic [31:0]              fpu_opb,
    output logic                     fpu_fsub,
    output logic                     fpu_new,
    input  logic                     fpu_busy,
    input  logic [34:0]              fpu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [34:0]              res_data,
    output logic [IDW-1:0]           res_id,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     res_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
    logic [IDW-1:0]     win_idx;
    logic               win_found;
    logic               hs;
    logic [7:0]         wd_q;
    logic [31:0]        opa_q;
    logic [31:0]        opb_q;
    logic               fsub_q;
    logic               new_q;
    logic [TAG_W-1:0]   tag_q;
    logic [IDW-1:0]     id_q;
    logic               valid_q;
    logic               err_q;
    logic [34:0]        data_q;

    // (base + off) mod NUM_REQ; both operands are already below NUM_REQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
        return s[IDW-1:0];
    endfunction

    // First valid requester at or after the pointer, with wrap-around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[wrap_add(ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(ptr_q, k);
            end
        end
    end

    assign hs    = (state_q == IDLE) && win_found && rst_n;
    assign ptr_d = wrap_add(win_idx, 1);

    always_comb begin
        req_ready = '0;
        if (hs) req_ready[win_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            fsub_q  <= 1'b0;
            new_q   <= 1'b0;
            tag_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        opa_q   <= req_opa[32*win_idx +: 32];
                        opb_q   <= req_opb[32*win_idx +: 32];
                        fsub_q  <= req_fsub[win_idx];
                        tag_q   <= req_tag[TAG_W*win_idx +: TAG_W];
                        id_q    <= win_idx;
                        ptr_q   <= ptr_d;
                        new_q   <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    new_q   <= 1'b0;
                    wd_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!fpu_busy) begin
                        data_q  <= fpu_out;
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else if (wd_q == 8'(TIMEOUT - 1)) begin
                        // Adder never finished: report an error with a zeroed result.
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fpu_opa   = opa_q;
    assign fpu_opb   = opb_q;
    assign fpu_fsub  = fsub_q;
    assign fpu_new   = new_q;
    assign res_valid = valid_q;
    assign res_data  = data_q;
    assign res_id    = id_q;
    assign res_tag   = tag_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_fpu_add_arb.sv
// Bench for fpu_add_arb: a stub adder with programmable shift count or a stuck busy flag,
// and a round-robin reference model for the grant order and the returned results.
module tb_fpu_add_arb;
    localparam int N   = 2;
    localparam int TW  = 4;
    localparam int TO  = 63;
    localparam int IDW = $clog2(N);

    logic              clk, rst_n;
    logic [N-1:0]      req_valid, req_ready, req_fsub;
    logic [32*N-1:0]   req_opa, req_opb;
    logic [TW*N-1:0]   req_tag;
    logic [31:0]       fpu_opa, fpu_opb;
    logic              fpu_fsub, fpu_new, fpu_busy;
    logic [34:0]       fpu_out, res_data;
    logic              res_valid, res_ready, res_err;
    logic [IDW-1:0]    res_id;
    logic [TW-1:0]     res_tag;

    int n_chk, n_pass;

    fpu_add_arb #(.NUM_REQ(N), .TAG_W(TW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opa(req_opa), .req_opb(req_opb),
        .req_fsub(req_fsub), .req_tag(req_tag),
        .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_fsub(fpu_fsub), .fpu_new(fpu_new),
        .fpu_busy(fpu_busy), .fpu_out(fpu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_tag(res_tag), .res_err(res_err)
    );

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    // Stand-in adder: known results for the fixed cases, an opaque mix otherwise.
    function automatic logic [34:0] fake_add(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (!s && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 3'b000};
        if (!s && a == 32'h7F800000 && b == 32'h3F800000) return {32'h7F800000, 3'b000};
        return {a ^ {b[15:0], b[31:16]} ^ {31'd0, s}, a[2:0] ^ b[2:0]};
    endfunction

    int unsigned shifts_cfg;
    bit          stuck;
    logic [15:0] acnt;
    logic [34:0] aout;
    always @(posedge clk) begin
        if (!rst_n) begin
            acnt <= '0; aout <= '0;
        end else if (fpu_new) begin
            acnt <= stuck ? 16'hFFFF : 16'(shifts_cfg);
            aout <= fake_add(fpu_opa, fpu_opb, fpu_fsub);
        end else if (acnt != 0 && !stuck) begin
            acnt <= acnt - 16'd1;
        end
    end
    assign fpu_busy = (acnt != 0);
    assign fpu_out  = aout;

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [TW-1:0] t);
        req_opa[32*i +: 32] = a;
        req_opb[32*i +: 32] = b;
        req_fsub[i]         = s;
        req_tag[TW*i +: TW] = t;
        req_valid[i]        = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output bit got, output int cyc);
        got = 1'b0; cyc = 0;
        while (cyc < limit) begin
            if (res_valid === 1'b1) begin got = 1'b1; return; end
            @(negedge clk); cyc++;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b exp 0", req_ready); else n_pass++;
        n_chk++; if (fpu_new !== 1'b0) $display("FAIL reset_fpu_new: got %b exp 0", fpu_new); else n_pass++;
        n_chk++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b exp 0", res_valid); else n_pass++;
        n_chk++; if (res_err !== 1'b0) $display("FAIL reset_res_err: got %b exp 0", res_err); else n_pass++;
        n_chk++; if (res_data !== '0) $display("FAIL reset_res_data: got %h exp 0", res_data); else n_pass++;
        n_chk++; if (res_id !== '0) $display("FAIL reset_res_id: got %0d exp 0", res_id); else n_pass++;
        n_chk++; if (res_tag !== '0) $display("FAIL reset_res_tag: got %0d exp 0", res_tag); else n_pass++;
        n_chk++; if (fpu_opa !== '0) $display("FAIL reset_fpu_opa: got %h exp 0", fpu_opa); else n_pass++;
        n_chk++; if (fpu_opb !== '0) $display("FAIL reset_fpu_opb: got %h exp 0", fpu_opb); else n_pass++;
        n_chk++; if (fpu_fsub !== 1'b0) $display("FAIL reset_fpu_fsub: got %b exp 0", fpu_fsub); else n_pass++;
        req_valid = '0; rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b exp 0", res_valid); else n_pass++;
    endtask

    task automatic test_single();
        bit got; int cyc;
        shifts_cfg = 2;
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0, 4'd5); #1;
        n_chk++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b exp 01", req_ready); else n_pass++;
        @(negedge clk); req_valid = '0;
        n_chk++; if (fpu_new !== 1'b1) $display("FAIL single_new_hi: got %b exp 1", fpu_new); else n_pass++;
        n_chk++; if (fpu_opa !== 32'h3F800000) $display("FAIL single_opa: got %h exp 3f800000", fpu_opa); else n_pass++;
        n_chk++; if (req_ready !== '0) $display("FAIL single_ready_issue: got %b exp 0", req_ready); else n_pass++;
        @(negedge clk);
        n_chk++; if (fpu_new !== 1'b0) $display("FAIL single_new_lo: got %b exp 0", fpu_new); else n_pass++;
        wait_valid(50, got, cyc);
        n_chk++; if (!got) $display("FAIL single_timeout: no res_valid within 50 cycles"); else n_pass++;
        n_chk++; if (res_data[34:3] !== 32'h40400000) $display("FAIL single_data: got %h exp 40400000", res_data[34:3]); else n_pass++;
        n_chk++; if (res_id !== '0) $display("FAIL single_id: got %0d exp 0", res_id); else n_pass++;
        n_chk++; if (res_tag !== 4'd5) $display("FAIL single_tag: got %0d exp 5", res_tag); else n_pass++;
        n_chk++; if (res_err !== 1'b0) $display("FAIL single_err: got %b exp 0", res_err); else n_pass++;
        consume();
        n_chk++; if (res_valid !== 1'b0) $display("FAIL single_drop: got %b exp 0", res_valid); else n_pass++;
    endtask

    // Reference: grant goes to the first valid requester at/after ptr_m, ptr_m then moves past it.
    task automatic test_arbitration(input int nops, input bit rnd);
        logic [31:0]   m_a [N];
        logic [31:0]   m_b [N];
        logic          m_s [N];
        logic [TW-1:0] m_t [N];
        logic [N-1:0]  mask;
        logic [31:0]   ex_a, ex_b;
        logic          ex_s;
        logic [TW-1:0] ex_t;
        int ptr_m, w;
        bit got;
        rst_n = 1'b0; req_valid = '0; @(negedge clk); rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            m_a[i] = $urandom; m_b[i] = $urandom; m_s[i] = 1'($urandom); m_t[i] = TW'($urandom);
        end
        mask = '1;
        for (int op = 0; op < nops; op++) begin
            if (rnd) mask = N'($urandom_range(1, (1 << N) - 1));
            shifts_cfg = $urandom_range(0, 5);
            for (int i = 0; i < N; i++) begin
                if (mask[i]) set_req(i, m_a[i], m_b[i], m_s[i], m_t[i]);
                else req_valid[i] = 1'b0;
            end
            #1;
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && mask[(ptr_m + k) % N]) w = (ptr_m + k) % N;
            n_chk++; if (req_ready !== N'(1 << w)) $display("FAIL arb_grant op%0d: got %b exp %b", op, req_ready, N'(1 << w)); else n_pass++;
            ex_a = m_a[w]; ex_b = m_b[w]; ex_s = m_s[w]; ex_t = m_t[w];
            @(negedge clk);
            // Winner presents a fresh request; losers keep theirs.
            m_a[w] = $urandom; m_b[w] = $urandom; m_s[w] = 1'($urandom); m_t[w] = TW'($urandom);
            set_req(w, m_a[w], m_b[w], m_s[w], m_t[w]);
            n_chk++; if (fpu_new !== 1'b1) $display("FAIL arb_new op%0d: got %b exp 1", op, fpu_new); else n_pass++;
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (res_valid === 1'b1) got = 1'b1;
                else if (fpu_busy) begin
                    n_chk++; if (fpu_opa !== ex_a) $display("FAIL arb_opa_stable op%0d: got %h exp %h", op, fpu_opa, ex_a); else n_pass++;
                end
            end
            n_chk++; if (!got) $display("FAIL arb_timeout op%0d: no res_valid", op); else n_pass++;
            n_chk++; if (res_data !== fake_add(ex_a, ex_b, ex_s)) $display("FAIL arb_data op%0d: got %h exp %h", op, res_data, fake_add(ex_a, ex_b, ex_s)); else n_pass++;
            n_chk++; if (res_id !== IDW'(w)) $display("FAIL arb_id op%0d: got %0d exp %0d", op, res_id, w); else n_pass++;
            n_chk++; if (res_tag !== ex_t) $display("FAIL arb_tag op%0d: got %0d exp %0d", op, res_tag, ex_t); else n_pass++;
            ptr_m = (w + 1) % N;
            consume();
        end
        req_valid = '0;
    endtask

    task automatic test_special();
        bit got; int cyc;
        shifts_cfg = 0;
        set_req(0, 32'h7F800000, 32'h3F800000, 1'b0, 4'd9); #1;
        n_chk++; if (req_ready !== 2'b01) $display("FAIL special_ready: got %b exp 01", req_ready); else n_pass++;
        @(negedge clk); req_valid = '0;
        wait_valid(50, got, cyc);
        n_chk++; if (!got || cyc != 2) $display("FAIL special_latency: got %0d exp 2 cycles after strobe", cyc); else n_pass++;
        n_chk++; if (res_data[34:3] !== 32'h7F800000) $display("FAIL special_data: got %h exp 7f800000", res_data[34:3]); else n_pass++;
        consume();
    endtask

    task automatic test_timeout();
        bit got; int cyc;
        logic [31:0] a, b;
        stuck = 1'b1;
        set_req(1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 4'd3); #1;
        @(negedge clk); req_valid = '0;
        wait_valid(200, got, cyc);
        n_chk++; if (!got || cyc != TO + 1) $display("FAIL timeout_latency: got %0d exp %0d", cyc, TO + 1); else n_pass++;
        n_chk++; if (res_err !== 1'b1) $display("FAIL timeout_err: got %b exp 1", res_err); else n_pass++;
        n_chk++; if (res_data !== '0) $display("FAIL timeout_data: got %h exp 0", res_data); else n_pass++;
        n_chk++; if (res_tag !== 4'd3) $display("FAIL timeout_tag: got %0d exp 3", res_tag); else n_pass++;
        consume();
        stuck = 1'b0; shifts_cfg = 1;
        a = $urandom; b = $urandom;
        set_req(0, a, b, 1'b0, 4'd7); #1;
        @(negedge clk); req_valid = '0;
        wait_valid(50, got, cyc);
        n_chk++; if (!got || res_err !== 1'b0) $display("FAIL after_timeout_err: got valid=%b err=%b exp 1/0", got, res_err); else n_pass++;
        n_chk++; if (res_data !== fake_add(a, b, 1'b0)) $display("FAIL after_timeout_data: got %h exp %h", res_data, fake_add(a, b, 1'b0)); else n_pass++;
        consume();
    endtask

    task automatic test_backpressure();
        bit got; int cyc;
        logic [31:0] a, b;
        logic [34:0] exp_d;
        shifts_cfg = 1;
        a = $urandom; b = $urandom; exp_d = fake_add(a, b, 1'b1);
        set_req(0, a, b, 1'b1, 4'd2); #1;
        @(negedge clk); req_valid = '0;
        set_req(1, 32'h1, 32'h2, 1'b0, 4'd1);
        wait_valid(50, got, cyc);
        n_chk++; if (!got) $display("FAIL bp_timeout: no res_valid"); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_chk++; if (res_valid !== 1'b1 || res_data !== exp_d || req_ready !== '0)
                $display("FAIL bp_hold c%0d: got v=%b d=%h rdy=%b exp 1 %h 0", c, res_valid, res_data, req_ready, exp_d);
            else n_pass++;
        end
        res_ready = 1'b1; #1;
        n_chk++; if (req_ready !== '0) $display("FAIL bp_same_cycle: got %b exp 0", req_ready); else n_pass++;
        @(negedge clk); res_ready = 1'b0;
        n_chk++; if (res_valid !== 1'b0) $display("FAIL bp_release_valid: got %b exp 0", res_valid); else n_pass++;
        n_chk++; if (req_ready !== 2'b10) $display("FAIL bp_release_idle: got %b exp 10", req_ready); else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_reset_in_wait();
        shifts_cfg = 10;
        set_req(0, 32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 4'd6); #1;
        @(negedge clk); req_valid = '0;
        repeat (2) @(negedge clk);
        n_chk++; if (fpu_busy !== 1'b1 || fpu_fsub !== 1'b1) $display("FAIL rstw_setup: got busy=%b fsub=%b exp 1 1", fpu_busy, fpu_fsub); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b0 || fpu_new !== 1'b0 || res_err !== 1'b0 || req_ready !== '0)
            $display("FAIL rstw_ctrl: got v=%b new=%b err=%b rdy=%b exp 0", res_valid, fpu_new, res_err, req_ready);
        else n_pass++;
        n_chk++; if (fpu_opa !== '0 || fpu_opb !== '0 || fpu_fsub !== 1'b0)
            $display("FAIL rstw_ops: got %h %h %b exp 0", fpu_opa, fpu_opb, fpu_fsub);
        else n_pass++;
        n_chk++; if (res_data !== '0 || res_id !== '0 || res_tag !== '0)
            $display("FAIL rstw_res: got %h %0d %0d exp 0", res_data, res_id, res_tag);
        else n_pass++;
        rst_n = 1'b1;
        req_valid = 2'b11; #1;
        n_chk++; if (req_ready !== 2'b01) $display("FAIL rstw_ptr: got %b exp 01", req_ready); else n_pass++;
        req_valid = '0;
        repeat (12) @(negedge clk);
        n_chk++; if (res_valid !== 1'b0) $display("FAIL rstw_no_result: got %b exp 0", res_valid); else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; req_valid = '0; req_opa = '0; req_opb = '0; req_fsub = '0; req_tag = '0;
        res_ready = 1'b0; shifts_cfg = 0; stuck = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_arbitration(4, 1'b0);
        test_special();
        test_timeout();
        test_backpressure();
        test_arbitration(20, 1'b1);
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1);
    end
endmodule
